// File: rtl/spi_cmd_receiver.sv
// rtl/spi_cmd_receiver.sv - SPI mode-0 slave that deserialises command words for cmdParser
// Oversamples SCK/MOSI/CS_n in the i_clk domain and returns i_status on MISO, MSB first.
module spi_cmd_receiver #(
  parameter int WORDLEN     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sck,
  input  logic               i_mosi,
  input  logic               i_cs_n,
  output logic               o_miso,
  input  logic [WORDLEN-1:0] i_status,
  output logic [WORDLEN-1:0] o_mem,
  output logic               o_shiftedIn,
  output logic               o_frameErr,
  output logic [7:0]         o_wordCount
);

  localparam int CNTW = $clog2(WORDLEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } stateType;

  stateType state;

  logic [SYNC_STAGES-1:0] sckSync;
  logic [SYNC_STAGES-1:0] mosiSync;
  logic [SYNC_STAGES-1:0] csSync;
  logic                   sckPrev;
  logic                   csPrev;

  logic                   sckS;
  logic                   mosiS;
  logic                   csS;
  logic                   sckRise;
  logic                   sckFall;
  logic                   csRise;
  logic                   csFall;

  logic [WORDLEN-2:0]     rxShift;
  logic [WORDLEN-2:0]     txShift;
  logic [CNTW-1:0]        bitCnt;
  logic                   lastBit;
  logic                   wordPend;
  logic                   strobeHold;

  // CS_n synchroniser resets to its inactive level so reset never fakes a falling edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sckSync  <= '0;
      mosiSync <= '0;
      csSync   <= '1;
      sckPrev  <= 1'b0;
      csPrev   <= 1'b1;
    end else begin
      sckSync  <= {sckSync[SYNC_STAGES-2:0], i_sck};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], i_mosi};
      csSync   <= {csSync[SYNC_STAGES-2:0], i_cs_n};
      sckPrev  <= sckS;
      csPrev   <= csS;
    end
  end

  assign sckS    = sckSync[SYNC_STAGES-1];
  assign mosiS   = mosiSync[SYNC_STAGES-1];
  assign csS     = csSync[SYNC_STAGES-1];
  assign sckRise = sckS & ~sckPrev;
  assign sckFall = ~sckS & sckPrev;
  assign csRise  = csS & ~csPrev;
  assign csFall  = ~csS & csPrev;
  assign lastBit = (bitCnt == CNTW'(WORDLEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      rxShift     <= '0;
      txShift     <= '0;
      bitCnt      <= '0;
      o_mem       <= '0;
      o_wordCount <= 8'd0;
      o_miso      <= 1'b0;
      o_frameErr  <= 1'b0;
      o_shiftedIn <= 1'b0;
      wordPend    <= 1'b0;
      strobeHold  <= 1'b0;
    end else begin
      o_frameErr <= 1'b0;
      wordPend   <= 1'b0;

      // Strobe trails the o_mem update by one cycle and stays up for two
      if (wordPend) begin
        o_shiftedIn <= 1'b1;
        strobeHold  <= 1'b1;
      end else if (strobeHold) begin
        strobeHold  <= 1'b0;
      end else begin
        o_shiftedIn <= 1'b0;
      end

      case (state)
        IDLE: begin
          o_miso <= 1'b0;
          bitCnt <= '0;
          if (csFall) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          txShift <= i_status[WORDLEN-2:0];
          o_miso  <= i_status[WORDLEN-1];
          state   <= SHIFT;
          if (csRise) begin
            o_miso <= 1'b0;
            state  <= IDLE;
          end
        end

        SHIFT: begin
          if (sckRise) begin
            rxShift <= {rxShift[WORDLEN-3:0], mosiS};
            if (lastBit) begin
              o_mem       <= {rxShift, mosiS};
              bitCnt      <= '0;
              o_wordCount <= o_wordCount + 8'd1;
              wordPend    <= 1'b1;
              txShift     <= i_status[WORDLEN-2:0];
              o_miso      <= i_status[WORDLEN-1];
            end else begin
              bitCnt <= bitCnt + CNTW'(1);
            end
          end else if (sckFall && bitCnt != '0) begin
            // At a word boundary the freshly reloaded MSB must survive the next falling edge
            txShift <= {txShift[WORDLEN-3:0], 1'b0};
            o_miso  <= txShift[WORDLEN-2];
          end

          if (csRise) begin
            state  <= IDLE;
            o_miso <= 1'b0;
            bitCnt <= '0;
            if (bitCnt != '0 && !(sckRise && lastBit)) begin
              o_frameErr <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb/tb_spi_cmd_receiver.sv - directed self-checking bench for spi_cmd_receiver
// Drives SPI mode-0 frames from tasks and checks o_mem, strobes, MISO and error pulses.
module tb_spi_cmd_receiver;

  logic        clk;
  logic        reset;
  logic        sck;
  logic        mosi;
  logic        csN;
  logic        miso;
  logic [63:0] status;
  logic [63:0] mem;
  logic        shiftedIn;
  logic        frameErr;
  logic [7:0]  wordCount;

  spi_cmd_receiver #(.WORDLEN(64), .SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_sck       (sck),
    .i_mosi      (mosi),
    .i_cs_n      (csN),
    .o_miso      (miso),
    .i_status    (status),
    .o_mem       (mem),
    .o_shiftedIn (shiftedIn),
    .o_frameErr  (frameErr),
    .o_wordCount (wordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] misoCap;
  int          lastRiseCyc;

  // Passive monitor: records events only, all comparisons happen in the main sequence
  logic [63:0] prevMem = '0;
  logic        prevStrobe = 1'b0;
  logic        prevErr = 1'b0;
  int          memChangeCyc = 0;
  int          strobeRiseCyc = 0;
  int          strobeCount = 0;
  int          runLen = 0;
  int          errPulses = 0;
  int          errRun = 0;
  int          errMaxRun = 0;
  logic [63:0] memLog[$];
  int          riseLog[$];
  int          runLog[$];

  always @(negedge clk) begin
    if (mem !== prevMem) memChangeCyc = cyc;
    prevMem = mem;
    if (shiftedIn && !prevStrobe) begin
      strobeCount++;
      strobeRiseCyc = cyc;
      memLog.push_back(mem);
      riseLog.push_back(cyc);
      runLen = 1;
    end else if (shiftedIn) begin
      runLen++;
    end else if (prevStrobe && !reset) begin
      runLog.push_back(runLen);
    end
    prevStrobe = shiftedIn;
    if (frameErr && !prevErr) begin
      errPulses++;
      errRun = 1;
    end else if (frameErr) begin
      errRun++;
    end
    if (errRun > errMaxRun) errMaxRun = errRun;
    prevErr = frameErr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csLow();
    csN = 1'b0;
    waitClk(6);
  endtask

  task automatic csHigh(input int half);
    waitClk(half);
    csN = 1'b1;
    waitClk(8);
  endtask

  task automatic sendBits(input logic [63:0] w, input int nBits, input int half);
    for (int i = 0; i < nBits; i++) begin
      mosi = w[63-i];
      waitClk(half);
      misoCap = {misoCap[62:0], miso};
      sck = 1'b1;
      lastRiseCyc = cyc;
      waitClk(half);
      sck = 1'b0;
    end
  endtask

  typedef struct {
    logic [63:0] word;
    logic [63:0] stat;
    logic [7:0]  expCount;
  } frameVec_t;

  frameVec_t vecs[3];

  initial begin
    int sc;
    int base;
    int bad;
    int badWords;
    logic [7:0] b;

    vecs[0] = '{64'hDEAD_BEEF_0123_4567, 64'hA5A5_0000_FFFF_1234, 8'd2};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 8'd3};
    vecs[2] = '{64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 8'd4};

    sck = 1'b0; mosi = 1'b0; csN = 1'b1; status = '0; reset = 1'b1; misoCap = '0;
    waitClk(4);
    check("rst_mem", mem, 64'h0);
    check("rst_strobe", 64'(shiftedIn), 64'h0);
    check("rst_frameErr", 64'(frameErr), 64'h0);
    check("rst_wordCount", 64'(wordCount), 64'h0);
    check("rst_miso", 64'(miso), 64'h0);
    reset = 1'b0;
    waitClk(4);

    // Single frame with latency and strobe alignment
    csLow();
    sendBits(64'h0000_0000_0000_4101, 64, 4);
    csHigh(4);
    check("t1_mem", mem, 64'h4101);
    check("t1_wordCount", 64'(wordCount), 64'd1);
    check("t1_latency", 64'(memChangeCyc - lastRiseCyc), 64'd3);
    check("t1_strobeDelay", 64'(strobeRiseCyc - memChangeCyc), 64'd1);
    check("t1_strobeCount", 64'(strobeCount), 64'd1);
    check("t1_frameErr", 64'(errPulses), 64'd0);

    for (int v = 0; v < 3; v++) begin
      sc = strobeCount;
      status = vecs[v].stat;
      csLow();
      sendBits(vecs[v].word, 64, 4);
      csHigh(4);
      check("vec_mem", mem, vecs[v].word);
      check("vec_miso", misoCap, vecs[v].stat);
      check("vec_wordCount", 64'(wordCount), 64'(vecs[v].expCount));
      check("vec_strobes", 64'(strobeCount - sc), 64'd1);
      check("vec_misoIdle", 64'(miso), 64'h0);
    end

    // Two words back-to-back in one frame
    sc = strobeCount;
    status = '0;
    csLow();
    sendBits(64'h0204_727F_FF7F_FF04, 64, 4);
    sendBits(64'h0017_CE20_0808_0002, 64, 4);
    csHigh(4);
    check("b2b_strobes", 64'(strobeCount - sc), 64'd2);
    check("b2b_word0", memLog[memLog.size()-2], 64'h0204_727F_FF7F_FF04);
    check("b2b_word1", memLog[memLog.size()-1], 64'h0017_CE20_0808_0002);
    check("b2b_wordCount", 64'(wordCount), 64'd6);

    // Short frame of 40 bits
    sc = strobeCount;
    csLow();
    sendBits(64'h1234_5678_9ABC_DEF0, 40, 4);
    csHigh(4);
    check("short_errPulses", 64'(errPulses), 64'd1);
    check("short_errWidth", 64'(errMaxRun), 64'd1);
    check("short_strobes", 64'(strobeCount - sc), 64'd0);
    check("short_mem", mem, 64'h0017_CE20_0808_0002);
    check("short_wordCount", 64'(wordCount), 64'd6);

    // Reset after 30 bits, then a clean all-zero frame
    sc = strobeCount;
    csLow();
    sendBits(64'hFFFF_FFFF_FFFF_FFFF, 30, 4);
    reset = 1'b1; csN = 1'b1; sck = 1'b0;
    waitClk(3);
    reset = 1'b0;
    waitClk(8);
    check("rstmid_strobes", 64'(strobeCount - sc), 64'd0);
    check("rstmid_wordCount", 64'(wordCount), 64'd0);
    csLow();
    sendBits(64'h0, 64, 4);
    csHigh(4);
    check("rstmid_mem", mem, 64'h0);
    check("rstmid_strobes2", 64'(strobeCount - sc), 64'd1);
    check("rstmid_wordCount2", 64'(wordCount), 64'd1);
    check("rstmid_errPulses", 64'(errPulses), 64'd1);

    // 256 words at SCK = clk/4 from a fresh reset
    reset = 1'b1;
    waitClk(3);
    reset = 1'b0;
    waitClk(4);
    sc = strobeCount;
    base = riseLog.size();
    csLow();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      sendBits({8{b}}, 64, 2);
    end
    csHigh(2);
    check("wrap_wordCount", 64'(wordCount), 64'd0);
    check("wrap_strobes", 64'(strobeCount - sc), 64'd256);
    bad = 0;
    badWords = 0;
    if (riseLog.size() >= base + 256) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'(i);
        if (memLog[base+i] !== {8{b}}) badWords++;
        if (i > 0 && riseLog[base+i] - riseLog[base+i-1] != 256) bad++;
      end
    end else begin
      bad = 1;
    end
    check("wrap_spacing", 64'(bad), 64'd0);
    check("wrap_words", 64'(badWords), 64'd0);
    check("wrap_errPulses", 64'(errPulses), 64'd1);

    bad = 0;
    foreach (runLog[i]) if (runLog[i] != 2) bad++;
    check("strobe_widths", 64'(bad), 64'd0);
    check("strobe_falls", 64'(runLog.size()), 64'(strobeCount));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
